// File: rtl/n8_way_dmux16_reg.sv
// Registered 8-way demultiplexer: one producer stream is steered into eight valid/ack holding slots.
// Optional stall counter (stall_cnt/stall_clr) is built when N8_WAY_DMUX16_STALL_CNT_EN is defined.
module n8_way_dmux16_reg #(
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
`ifdef N8_WAY_DMUX16_STALL_CNT_EN
    input  logic                stall_clr,
    output logic [15:0]         stall_cnt,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [2:0]          in_sel,
    output logic [7:0]          out_valid,
    output logic [8*DATA_W-1:0] out_data,
    input  logic [7:0]          out_ack
);

    logic [7:0]             valid_q, valid_d;
    logic [7:0][DATA_W-1:0] data_q, data_d;
    logic                   accept;

    // A full slot still accepts when its consumer drains it in the same cycle.
    assign in_ready = ~valid_q[in_sel] | out_ack[in_sel];
    assign accept   = in_valid & in_ready;

    always_comb begin
        valid_d = valid_q & ~out_ack;
        data_d  = data_q;
        if (accept) begin
            valid_d[in_sel] = 1'b1;
            data_d[in_sel]  = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

`ifdef N8_WAY_DMUX16_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where the producer was held off; clear wins.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (in_valid && !in_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_n8_way_dmux16_reg.sv
// Self-checking bench for n8_way_dmux16_reg: directed vector table, random traffic against a
// slot-array model, asynchronous reset mid-run, and stall counter checks when the macro is defined.
module tb_n8_way_dmux16_reg;

    localparam int DATA_W = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic [2:0]          in_sel;
    logic [7:0]          out_valid;
    logic [8*DATA_W-1:0] out_data;
    logic [7:0]          out_ack;
`ifdef N8_WAY_DMUX16_STALL_CNT_EN
    logic                stall_clr;
    logic [15:0]         stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: each slot is simply "holds a word or not" plus the word.
    bit          m_valid [8];
    logic [15:0] m_data  [8];
    int          m_stall;
    bit          m_last_stall;

    typedef struct {
        logic        v;
        logic [2:0]  s;
        logic [15:0] d;
        logic [7:0]  a;
        logic        exp_rdy;
        logic [7:0]  exp_vld;
    } vec_t;

    vec_t tbl [26];

    n8_way_dmux16_reg #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef N8_WAY_DMUX16_STALL_CNT_EN
        .stall_clr (stall_clr),
        .stall_cnt (stall_cnt),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ack   (out_ack)
    );

    always #5 clk = ~clk;

    function automatic logic model_ready();
        return !m_valid[in_sel] || out_ack[in_sel];
    endfunction

    function automatic logic [7:0] model_valid_vec();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = m_valid[i];
        return r;
    endfunction

    function automatic logic [15:0] slot(input int i);
        return out_data[i*DATA_W +: DATA_W];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
        end
        m_stall      = 0;
        m_last_stall = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check($sformatf("%s in_ready", tag), {31'd0, in_ready}, {31'd0, model_ready()});
        check($sformatf("%s out_valid", tag), {24'd0, out_valid}, {24'd0, model_valid_vec()});
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i]) check($sformatf("%s slot%0d", tag, i), {16'd0, slot(i)}, {16'd0, m_data[i]});
        end
`ifdef N8_WAY_DMUX16_STALL_CNT_EN
        check($sformatf("%s stall_cnt", tag), {16'd0, stall_cnt}, m_stall);
`endif
    endtask

    // Advance the model by one edge using the inputs currently applied, then take the edge.
    task automatic finishCycle();
        bit rdy;
        bit clr;
        rdy = model_ready();
        clr = 1'b0;
`ifdef N8_WAY_DMUX16_STALL_CNT_EN
        clr = stall_clr;
`endif
        m_last_stall = in_valid && !rdy;
        if (clr) m_stall = 0;
        else if (m_last_stall && m_stall < 65535) m_stall++;
        for (int i = 0; i < 8; i++) if (out_ack[i]) m_valid[i] = 1'b0;
        if (in_valid && rdy) begin
            m_valid[in_sel] = 1'b1;
            m_data[in_sel]  = in_data;
        end
        @(posedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] s, input logic [15:0] d, input logic [7:0] a);
        @(negedge clk);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        out_ack  = a;
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 3'd3, 16'hBEEF, 8'h00, 1'b1, 8'h00};
        tbl[1]  = '{1'b0, 3'd0, 16'h0000, 8'h08, 1'b1, 8'h08};
        tbl[2]  = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 8'h00};
        tbl[3]  = '{1'b1, 3'd6, 16'h6666, 8'h00, 1'b1, 8'h00};
        tbl[4]  = '{1'b1, 3'd6, 16'h1234, 8'h00, 1'b0, 8'h40};
        tbl[5]  = '{1'b1, 3'd6, 16'h1234, 8'h00, 1'b0, 8'h40};
        tbl[6]  = '{1'b1, 3'd6, 16'h1234, 8'h40, 1'b1, 8'h40};
        tbl[7]  = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 8'h40};
        tbl[8]  = '{1'b0, 3'd0, 16'h0000, 8'h40, 1'b1, 8'h40};
        tbl[9]  = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 8'h00};
        for (int k = 0; k < 8; k++) begin
            tbl[10+k] = '{1'b1, 3'(k), 16'(16'h0010*k + 1), 8'h00, 1'b1, 8'((1 << k) - 1)};
        end
        tbl[18] = '{1'b0, 3'd0, 16'h0000, 8'hFF, 1'b1, 8'hFF};
        tbl[19] = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 8'h00};
        tbl[20] = '{1'b1, 3'd0, 16'hAAAA, 8'h00, 1'b1, 8'h00};
        tbl[21] = '{1'b1, 3'd1, 16'h5555, 8'h00, 1'b1, 8'h01};
        tbl[22] = '{1'b0, 3'd1, 16'h0000, 8'h00, 1'b0, 8'h03};
        tbl[23] = '{1'b0, 3'd0, 16'h0000, 8'h80, 1'b0, 8'h03};
        tbl[24] = '{1'b0, 3'd0, 16'h0000, 8'h03, 1'b1, 8'h03};
        tbl[25] = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 8'h00};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_sel   = '0;
        in_data  = '0;
        out_ack  = '0;
`ifdef N8_WAY_DMUX16_STALL_CNT_EN
        stall_clr = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset out_valid", {24'd0, out_valid}, 32'h0);
        check("reset out_data", {31'd0, |out_data}, 32'h0);
        check("reset in_ready", {31'd0, in_ready}, 32'h1);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 26; i++) begin
            applyStimulus(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].a);
            check($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_rdy});
            check($sformatf("vec%0d out_valid", i), {24'd0, out_valid}, {24'd0, tbl[i].exp_vld});
            case (i)
                1:  check("vec1 slot3", {16'd0, slot(3)}, 32'hBEEF);
                5:  check("vec5 slot6 held", {16'd0, slot(6)}, 32'h6666);
                7:  check("vec7 slot6 replaced", {16'd0, slot(6)}, 32'h1234);
                18: for (int k = 0; k < 8; k++)
                        check($sformatf("sweep slot%0d", k), {16'd0, slot(k)}, 16'h0010*k + 1);
                22: begin
                        check("vec22 slot0", {16'd0, slot(0)}, 32'hAAAA);
                        check("vec22 slot1", {16'd0, slot(1)}, 32'h5555);
                    end
                default: ;
            endcase
            checkOutput($sformatf("vec%0d", i));
            finishCycle();
        end

        // Random traffic; the producer holds sel/data while stalled
        for (int n = 0; n < 400; n++) begin
            logic       v;
            logic [2:0] s;
            logic [15:0] d;
            if (m_last_stall) begin
                v = 1'b1;
                s = in_sel;
                d = in_data;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                s = 3'($urandom_range(0, 7));
                d = 16'($urandom);
            end
            applyStimulus(v, s, d, 8'($urandom) & 8'($urandom));
            checkOutput($sformatf("rand%0d", n));
            finishCycle();
        end

        // Asynchronous reset mid-cycle with slots 2 and 5 full
        applyStimulus(1'b0, 3'd0, 16'h0, 8'hFF);
        finishCycle();
        applyStimulus(1'b1, 3'd2, 16'h2222, 8'h00);
        finishCycle();
        applyStimulus(1'b1, 3'd5, 16'h5555, 8'h00);
        finishCycle();
        applyStimulus(1'b1, 3'd2, 16'h7777, 8'h00);
        check("pre-reset out_valid", {24'd0, out_valid}, 32'h24);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check("async reset out_valid", {24'd0, out_valid}, 32'h0);
        check("async reset out_data", {31'd0, |out_data}, 32'h0);
        check("async reset in_ready", {31'd0, in_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("post-reset");

`ifdef N8_WAY_DMUX16_STALL_CNT_EN
        applyStimulus(1'b1, 3'd4, 16'h4444, 8'h00);
        finishCycle();
        for (int n = 0; n < 5; n++) begin
            applyStimulus(1'b1, 3'd4, 16'h9999, 8'h00);
            finishCycle();
        end
        applyStimulus(1'b0, 3'd4, 16'h9999, 8'h00);
        check("stall five", {16'd0, stall_cnt}, 32'd5);
        finishCycle();
        applyStimulus(1'b1, 3'd4, 16'h9999, 8'h00);
        stall_clr = 1'b1;
        finishCycle();
        @(negedge clk);
        stall_clr = 1'b0;
        #1;
        check("stall clear", {16'd0, stall_cnt}, 32'd0);
        repeat (65540) finishCycle();
        @(negedge clk);
        #1;
        check("stall saturate", {16'd0, stall_cnt}, 32'hFFFF);
        checkOutput("stall end");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/n8_way_dmux16_reg.md
Name: n8_way_dmux16_reg

Overview:
Registered 8-way, 16-bit demultiplexer; the distribution-side counterpart of the 8-way 16-bit mux. One input stream carries a word and a 3-bit lane select. Each word is steered into one of eight output holding slots. Each slot presents its word with a valid flag until its consumer acknowledges it. It sits between a single producer (e.g. the ALU/CPU write path) and eight independent consumers (register/RAM banks).

Parameters:
DATA_W, 16, width of each data word and of each output slot.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  producer has a word on in_data/in_sel.
in_ready  output  1  block accepts the word this cycle.
in_data  input  DATA_W  word to distribute.
in_sel  input  3  destination lane 0..7 (0 maps to lane a, 7 maps to lane h).
out_valid  output  8  bit i high: slot i holds an unconsumed word.
out_data  output  8*DATA_W  slot i word on bits [i*DATA_W +: DATA_W].
out_ack  input  8  bit i high: consumer i takes slot i's word this cycle.

Behaviour:
- Reset: applied asynchronously while rst=1.
  - All out_valid=0.
  - All out_data slots=0.
  - Stall counter (if built) =0.
  - in_ready is combinational and reads 1 after reset, since every slot is empty.
- Per-slot state: EMPTY (out_valid[i]=0) or FULL (out_valid[i]=1).
- in_ready = ~out_valid[in_sel] | out_ack[in_sel]. It is combinational from in_sel and out_ack and depends on no other slot.
- Transfer occurs when in_valid & in_ready on a rising edge. Effect on the next edge:
  - slot[in_sel] data <= in_data.
  - out_valid[in_sel] <= 1.
- Latency: an accepted word is visible on out_data/out_valid exactly 1 cycle after acceptance.
- Consume: out_ack[i] & out_valid[i] clears out_valid[i] next edge.
  - Slot data is retained; it is don't-care once invalid.
- out_ack[i] while out_valid[i]=0 is ignored, with no state change.
- Simultaneous consume and transfer to the same full slot:
  - The new word replaces the old one.
  - out_valid stays 1.
  - This gives full one-word-per-cycle throughput per lane.
- Transfers to different lanes are independent. Acks on several lanes in one cycle are all honoured.
- A transfer never disturbs any slot other than in_sel.
- in_sel/in_data are sampled only when in_valid=1. in_valid=0 causes no state change.
- Producer rule: in_data/in_sel must be held stable while in_valid=1 and in_ready=0. The block does not check this.
- Reset asserted mid-operation: all pending words are discarded immediately and out_valid goes to 0 asynchronously. No partial transfer completes.
- No wrap-around state. Lane index is a direct decode of in_sel, with all 8 values legal.

Optional Feature:
Macro N8_WAY_DMUX16_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, 16 bits, reset to 0.
  - It increments on each edge where in_valid=1 and in_ready=0.
  - It saturates at 16'hFFFF and does not wrap.
  - Adds input stall_clr, 1 bit. When 1, it synchronously zeroes the counter, and clear has priority over increment.
- Undefined: neither port exists and no counter logic is built. All other behaviour is identical.

Test Plan:
1. Reset: rst=1 mid-run with slots 2 and 5 full, then rst=0 -> out_valid=8'h00 immediately, all out_data=0, in_ready=1.
2. Single lane: in_valid=1, in_sel=3, in_data=16'hBEEF for one cycle -> next cycle out_valid=8'b0000_1000 and slot 3 = 16'hBEEF. out_ack[3]=1 for one cycle -> out_valid=0.
3. Full backpressure: slot 6 full, no ack, in_sel=6, in_data=16'h1234 -> in_ready=0 and slot 6 unchanged. Assert out_ack[6] -> in_ready=1 same cycle; next cycle slot 6 = 16'h1234 and out_valid[6]=1.
4. Sweep: sel 0..7 with data 16'h0010*sel+1 on consecutive cycles, no acks -> out_valid=8'hFF, each slot holds its own word. Then ack all 8 in one cycle -> out_valid=8'h00.
5. Lane independence: slot 0 full and unacked, in_sel=1 -> in_ready=1, slot 1 written, slot 0 unchanged.
6. Stall counter (macro on): hold in_valid=1 to a full unacked slot for 5 cycles -> stall_cnt=5. stall_clr=1 concurrent with a stall -> stall_cnt=0. Preload near max -> counter stays at 16'hFFFF.
